tf_exp_gen: RTL and testbench

//  Twiddle-exponent sequencer: the read initiator for the three registered twiddle ROM ports.
//  Per radix-4 butterfly it drives EXP1/EXP2/EXP3 = e, 2e, 3e (mod 2^EXP_W). TF0 = W^0 needs no exponent.

---
 rtl/tf_pkg.sv | 29 ++
 rtl/tf_exp_mul3.sv | 19 +
 rtl/tf_exp_gen.sv | 154 +++++++++++++++
 tb/tb_tf_exp_gen.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tf_pkg.sv
// Shared types and helpers for the twiddle-exponent sequencer.
// Holds the default exponent width, the sequencer state encoding and the
// exponent rule used by the issue side.
package tf_pkg;

    localparam int EXP_W_DFLT = 4;

    typedef logic [EXP_W_DFLT-1:0] tf_exp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } tf_state_t;

    // Width of the stage index for a given exponent width (at least one bit).
    function automatic int stage_w(input int ew);
        return ((ew / 2) > 1) ? $clog2(ew / 2) : 1;
    endfunction

    // Exponent of butterfly b in stage s: e = (b mod (NBF >> 2s)) << 2s.
    // The span is a power of two, so the modulo is a mask. The caller truncates.
    function automatic logic [31:0] exp_of(input int ew, input logic [31:0] s, input logic [31:0] b);
        logic [31:0] span;
        span = (32'd1 << (ew - 2)) >> (2 * s);
        return (b & (span - 32'd1)) << (2 * s);
    endfunction

endpackage

// File: rtl/tf_exp_mul3.sv
// Exponent fan-out for the three twiddle ROM ports: e -> {e, 2e mod N, 3e mod N}.
// Pure combinational; the mod-N wrap is the natural EXP_W-bit overflow.
module tf_exp_mul3 #(
    parameter int EXP_W = 4
) (
    input  logic [EXP_W-1:0] e,
    output logic [EXP_W-1:0] e1,
    output logic [EXP_W-1:0] e2,
    output logic [EXP_W-1:0] e3
);

    // Multiples of e, wrapped to the ROM depth.
    always_comb begin
        e1 = e;
        e2 = e << 1;
        e3 = e + (e << 1);
    end

endmodule

// File: rtl/tf_exp_gen.sv
// Twiddle-exponent sequencer: drives the three registered twiddle ROM ports
// with e, 2e, 3e per radix-4 butterfly and tags the beat that returns one
// clock later. STALL replays the exponents of the beat on TF so the ROM
// reloads the same words.
// Optional build macro TFGEN_BACK2BACK_EN: a START seen in the DONE cycle
// launches the next frame directly instead of being ignored.
module tf_exp_gen
    import tf_pkg::*;
#(
    parameter int EXP_W = EXP_W_DFLT
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic                      STALL,
    output logic [EXP_W-1:0]          EXP1,
    output logic [EXP_W-1:0]          EXP2,
    output logic [EXP_W-1:0]          EXP3,
    output logic                      TF_VLD,
    output logic [stage_w(EXP_W)-1:0] TF_STAGE,
    output logic                      TF_LAST,
    output logic                      BUSY,
    output logic                      DONE
);

    localparam int N      = 1 << EXP_W;
    localparam int STAGES = EXP_W / 2;
    localparam int NBF    = N / 4;
    localparam int SW     = stage_w(EXP_W);
    localparam int BW     = (EXP_W > 2) ? EXP_W - 2 : 1;

    typedef logic [EXP_W-1:0] exp_t;

    tf_state_t     state;
    logic [SW-1:0] s_p0;
    logic [BW-1:0] b_p0;
    exp_t          e_last_p0;
    logic          busy_q;
    logic          done_q;

    logic          vld_p1;
    logic          last_p1;
    logic [SW-1:0] stg_p1;
    exp_t          e_p1;

    logic          run;
    logic          iss;
    logic          last_beat;
    logic          start_ok;
    exp_t          e_iss;
    exp_t          iss1, iss2, iss3;
    exp_t          rep1, rep2, rep3;

`ifdef TFGEN_BACK2BACK_EN
    assign start_ok = START;
`else
    // The DONE cycle is still part of the finishing frame; a START there is dropped.
    assign start_ok = START && !done_q;
`endif

    // Issue-side decode: exponent of the beat at the counters, or the last one issued.
    always_comb begin
        run       = (state == RUN);
        iss       = run && !STALL;
        last_beat = (s_p0 == SW'(STAGES - 1)) && (b_p0 == BW'(NBF - 1));
        e_iss     = run ? exp_t'(exp_of(EXP_W, 32'(s_p0), 32'(b_p0))) : e_last_p0;
    end

    // Stage p0: sequencer FSM with stage/butterfly counters and registered status.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            s_p0      <= '0;
            b_p0      <= '0;
            e_last_p0 <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        s_p0   <= '0;
                        b_p0   <= '0;
                    end
                end
                RUN: begin
                    if (iss) begin
                        e_last_p0 <= e_iss;
                        if (last_beat) begin
                            state <= FLUSH;
                            s_p0  <= '0;
                            b_p0  <= '0;
                        end else if (b_p0 == BW'(NBF - 1)) begin
                            b_p0 <= '0;
                            s_p0 <= s_p0 + 1'b1;
                        end else begin
                            b_p0 <= b_p0 + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (vld_p1 && !STALL) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: tags of the beat now on the ROM outputs; frozen while stalled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            stg_p1  <= '0;
            e_p1    <= '0;
        end else if (!STALL) begin
            vld_p1  <= run;
            last_p1 <= run && last_beat;
            stg_p1  <= s_p0;
            e_p1    <= e_iss;
        end
    end

    tf_exp_mul3 #(.EXP_W(EXP_W)) u_mul_iss (
        .e  (e_iss),
        .e1 (iss1),
        .e2 (iss2),
        .e3 (iss3)
    );

    tf_exp_mul3 #(.EXP_W(EXP_W)) u_mul_rep (
        .e  (e_p1),
        .e1 (rep1),
        .e2 (rep2),
        .e3 (rep3)
    );

    assign EXP1     = STALL ? rep1 : iss1;
    assign EXP2     = STALL ? rep2 : iss2;
    assign EXP3     = STALL ? rep3 : iss3;
    assign TF_VLD   = vld_p1;
    assign TF_STAGE = stg_p1;
    assign TF_LAST  = last_p1;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_tf_exp_gen.sv
// Bench for tf_exp_gen: an EXP_W=4 and an EXP_W=6 instance, each feeding a
// registered ROM model, checked against a beat-list model of the frame.
module tb_tf_exp_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stall, start6, stall6;
    logic [3:0]  exp1, exp2, exp3;
    logic        tf_vld, tf_last, busy, done;
    logic [0:0]  tf_stage;
    logic [5:0]  x1, x2, x3;
    logic        v6, last6, busy6, done6;
    logic [1:0]  stage6;
    logic [15:0] tf1, tf2, tf3, q1, q2, q3;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    tf_exp_gen #(.EXP_W(4)) dut (
        .CLK(clk), .RST(rst), .START(start), .STALL(stall),
        .EXP1(exp1), .EXP2(exp2), .EXP3(exp3),
        .TF_VLD(tf_vld), .TF_STAGE(tf_stage), .TF_LAST(tf_last),
        .BUSY(busy), .DONE(done)
    );

    tf_exp_gen #(.EXP_W(6)) dut6 (
        .CLK(clk), .RST(rst), .START(start6), .STALL(stall6),
        .EXP1(x1), .EXP2(x2), .EXP3(x3),
        .TF_VLD(v6), .TF_STAGE(stage6), .TF_LAST(last6),
        .BUSY(busy6), .DONE(done6)
    );

    // Twiddle table contents: any injective function of the address.
    function automatic logic [15:0] rom(input int a);
        return 16'(a * 40503 + 12345);
    endfunction

    // Expected exponent of beat k of a frame of width ew.
    function automatic int exp_ref(input int ew, input int k);
        int nbf, s, b, span;
        nbf  = (1 << ew) / 4;
        s    = k / nbf;
        b    = k % nbf;
        span = nbf >> (2 * s);
        return (b % span) << (2 * s);
    endfunction

    // Registered ROM ports.
    always @(posedge clk) begin
        tf1 <= rom(int'(exp1));
        tf2 <= rom(int'(exp2));
        tf3 <= rom(int'(exp3));
        q1  <= rom(int'(x1));
        q2  <= rom(int'(x2));
        q3  <= rom(int'(x3));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; start6 = 1'b0; stall6 = 1'b0;
        repeat (2) step();
        #1;
        total++;
        if ({exp1, exp2, exp3, tf_vld, tf_stage, tf_last, busy, done} !== 16'd0) begin
            bad++;
            $display("FAIL reset4 got=%h want=0", {exp1, exp2, exp3, tf_vld, tf_stage, tf_last, busy, done});
        end
        total++;
        if ({x1, x2, x3, v6, stage6, last6, busy6, done6} !== 23'd0) begin
            bad++;
            $display("FAIL reset6 got=%h want=0", {x1, x2, x3, v6, stage6, last6, busy6, done6});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        int  e;
        logic want_vld;
        repeat (2) step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            #1;
            if (c <= 8) begin
                e = exp_ref(4, c - 1);
                total++;
                if (exp1 !== 4'(e) || exp3 !== 4'(3 * e)) begin
                    bad++;
                    $display("FAIL frame_exp c=%0d got=%0d,%0d want=%0d,%0d", c, exp1, exp3, e, 3 * e);
                end
            end
            want_vld = (c >= 2 && c <= 9);
            total++;
            if (tf_vld !== want_vld) begin
                bad++;
                $display("FAIL frame_vld c=%0d got=%0b want=%0b", c, tf_vld, want_vld);
            end
            if (want_vld) begin
                e = exp_ref(4, c - 2);
                total++;
                if ({tf1, tf2, tf3} !== {rom(e), rom((2 * e) % 16), rom((3 * e) % 16)} ||
                    tf_stage !== 1'((c - 2) / 4) || tf_last !== (c == 9)) begin
                    bad++;
                    $display("FAIL frame_beat c=%0d got=%h/%0d/%0b want=%h/%0d/%0b", c, {tf1, tf2, tf3}, tf_stage, tf_last,
                             {rom(e), rom((2 * e) % 16), rom((3 * e) % 16)}, (c - 2) / 4, (c == 9));
                end
            end
            total++;
            if (done !== (c == 10) || busy !== (c <= 9)) begin
                bad++;
                $display("FAIL frame_status c=%0d got=done%0b busy%0b want=done%0b busy%0b", c, done, busy, (c == 10), (c <= 9));
            end
            step();
        end
    endtask

    task automatic test_stall_replay();
        logic seen;
        repeat (2) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({exp1, exp2, exp3} !== {4'd2, 4'd4, 4'd6} || {tf1, tf2, tf3} !== {rom(2), rom(4), rom(6)} || tf_vld !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold i=%0d got=%0d,%0d,%0d vld=%0b tf=%h want=2,4,6 vld=1 tf=%h", i, exp1, exp2, exp3, tf_vld,
                         {tf1, tf2, tf3}, {rom(2), rom(4), rom(6)});
            end
            step();
        end
        stall = 1'b0;
        #1;
        total++;
        if (exp1 !== 4'd3 || tf1 !== rom(2)) begin
            bad++;
            $display("FAIL stall_release got=exp%0d tf1=%h want=exp3 tf1=%h", exp1, tf1, rom(2));
        end
        step();
        #1;
        total++;
        if (tf_vld !== 1'b1 || {tf1, tf2, tf3} !== {rom(3), rom(6), rom(9)}) begin
            bad++;
            $display("FAIL stall_next got=vld%0b tf=%h want=vld1 tf=%h", tf_vld, {tf1, tf2, tf3}, {rom(3), rom(6), rom(9)});
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL stall_done got=0 want=1");
        end
    endtask

    task automatic test_flush_stall();
        logic found;
        repeat (2) step();
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (tf_vld === 1'b1 && tf_last === 1'b1) found = 1'b1;
            else step();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL flush_last got=0 want=1");
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (done !== 1'b0 || busy !== 1'b1 || tf_vld !== 1'b1 || tf_last !== 1'b1) begin
                bad++;
                $display("FAIL flush_hold i=%0d got=done%0b busy%0b vld%0b last%0b want=0111", i, done, busy, tf_vld, tf_last);
            end
            step();
            #1;
        end
        stall = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL flush_consume got=done%0b busy%0b want=done0 busy1", done, busy);
        end
        step();
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || tf_vld !== 1'b0) begin
            bad++;
            $display("FAIL flush_done got=done%0b busy%0b vld%0b want=done1 busy0 vld0", done, busy, tf_vld);
        end
        step();
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL flush_pulse got=%0b want=0", done);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        repeat (2) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        total++;
        if ({exp1, exp2, exp3, tf_vld, tf_stage, tf_last, busy, done} !== 16'd0) begin
            bad++;
            $display("FAIL rst_mid got=%h want=0", {exp1, exp2, exp3, tf_vld, tf_stage, tf_last, busy, done});
        end
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            step();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rst_discard got=activity want=idle");
        end
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        total++;
        if (exp1 !== 4'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_restart got=exp%0d busy%0b want=exp0 busy1", exp1, busy);
        end
        step();
        #1;
        total++;
        if (tf_vld !== 1'b1 || tf1 !== rom(0) || tf_stage !== 1'b0) begin
            bad++;
            $display("FAIL rst_beat0 got=vld%0b tf1=%h stg%0d want=vld1 tf1=%h stg0", tf_vld, tf1, tf_stage, rom(0));
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_done got=0 want=1");
        end
    endtask

    task automatic test_start_held();
        logic seen;
        int   e;
        repeat (2) step();
        start = 1'b1;
        step();
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (c <= 8) begin
                e = exp_ref(4, c - 1);
                total++;
                if (exp1 !== 4'(e)) begin
                    bad++;
                    $display("FAIL held_exp c=%0d got=%0d want=%0d", c, exp1, e);
                end
            end
            total++;
            if (done !== (c == 10) || busy !== (c <= 9)) begin
                bad++;
                $display("FAIL held_status c=%0d got=done%0b busy%0b want=done%0b busy%0b", c, done, busy, (c == 10), (c <= 9));
            end
            step();
        end
        #1;
`ifdef TFGEN_BACK2BACK_EN
        total++;
        if (busy !== 1'b1 || exp1 !== 4'd0) begin
            bad++;
            $display("FAIL b2b_restart got=busy%0b exp%0d want=busy1 exp0", busy, exp1);
        end
`else
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL gap_idle got=busy%0b want=busy0", busy);
        end
        step();
        #1;
        total++;
        if (busy !== 1'b1 || exp1 !== 4'd0) begin
            bad++;
            $display("FAIL gap_restart got=busy%0b exp%0d want=busy1 exp0", busy, exp1);
        end
`endif
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL held_done2 got=0 want=1");
        end
    endtask

    task automatic test_random_stall();
        int   issued, consumed, e, h;
        logic want_done, fin;
        repeat (2) step();
        issued = 0; consumed = 0; want_done = 1'b0; fin = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            stall = ($urandom_range(0, 2) == 0);
            #1;
            total++;
            if (done !== want_done) begin
                bad++;
                $display("FAIL rnd_done cyc=%0d got=%0b want=%0b", cyc, done, want_done);
            end
            fin = want_done;
            want_done = 1'b0;
            if (tf_vld === 1'b1 && consumed >= 8) begin
                total++;
                bad++;
                $display("FAIL rnd_extra cyc=%0d got=vld1 want=vld0", cyc);
            end else if (tf_vld === 1'b1) begin
                h = exp_ref(4, consumed);
                total++;
                if ({tf1, tf2, tf3} !== {rom(h), rom((2 * h) % 16), rom((3 * h) % 16)} ||
                    tf_stage !== 1'(consumed / 4) || tf_last !== (consumed == 7)) begin
                    bad++;
                    $display("FAIL rnd_beat k=%0d got=%h/%0d/%0b want_e=%0d", consumed, {tf1, tf2, tf3}, tf_stage, tf_last, h);
                end
                if (stall) begin
                    total++;
                    if ({exp1, exp2, exp3} !== {4'(h), 4'(2 * h), 4'(3 * h)}) begin
                        bad++;
                        $display("FAIL rnd_replay k=%0d got=%0d,%0d,%0d want_e=%0d", consumed, exp1, exp2, exp3, h);
                    end
                end else begin
                    consumed++;
                    if (consumed == 8) want_done = 1'b1;
                end
            end
            if (!stall && busy === 1'b1 && issued < 8) begin
                e = exp_ref(4, issued);
                total++;
                if ({exp1, exp2, exp3} !== {4'(e), 4'(2 * e), 4'(3 * e)}) begin
                    bad++;
                    $display("FAIL rnd_issue k=%0d got=%0d,%0d,%0d want_e=%0d", issued, exp1, exp2, exp3, e);
                end
                issued++;
            end
            step();
        end
        stall = 1'b0;
        total++;
        if (!fin || consumed != 8) begin
            bad++;
            $display("FAIL rnd_end got=fin%0b beats%0d want=fin1 beats8", fin, consumed);
        end
    endtask

    task automatic test_exp_w6();
        int   issued, consumed, e, h, mx;
        logic want_done, fin;
        repeat (2) step();
        issued = 0; consumed = 0; mx = 0; want_done = 1'b0; fin = 1'b0;
        start6 = 1'b1;
        step();
        start6 = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            stall6 = ($urandom_range(0, 3) == 0);
            #1;
            total++;
            if (done6 !== want_done) begin
                bad++;
                $display("FAIL w6_done cyc=%0d got=%0b want=%0b", cyc, done6, want_done);
            end
            fin = want_done;
            want_done = 1'b0;
            if (v6 === 1'b1 && consumed >= 48) begin
                total++;
                bad++;
                $display("FAIL w6_extra cyc=%0d got=vld1 want=vld0", cyc);
            end else if (v6 === 1'b1) begin
                h = exp_ref(6, consumed);
                total++;
                if ({q1, q2, q3} !== {rom(h), rom((2 * h) % 64), rom((3 * h) % 64)} ||
                    stage6 !== 2'(consumed / 16) || last6 !== (consumed == 47)) begin
                    bad++;
                    $display("FAIL w6_beat k=%0d got=%h/%0d/%0b want_e=%0d", consumed, {q1, q2, q3}, stage6, last6, h);
                end
                if (stall6) begin
                    total++;
                    if ({x1, x2, x3} !== {6'(h), 6'(2 * h), 6'(3 * h)}) begin
                        bad++;
                        $display("FAIL w6_replay k=%0d got=%0d,%0d,%0d want_e=%0d", consumed, x1, x2, x3, h);
                    end
                end else begin
                    consumed++;
                    if (consumed == 48) want_done = 1'b1;
                end
            end
            if (!stall6 && busy6 === 1'b1 && issued < 48) begin
                e = exp_ref(6, issued);
                total++;
                if ({x1, x2, x3} !== {6'(e), 6'(2 * e), 6'(3 * e)}) begin
                    bad++;
                    $display("FAIL w6_issue k=%0d got=%0d,%0d,%0d want_e=%0d", issued, x1, x2, x3, e);
                end
                if (int'(x3) > mx) mx = int'(x3);
                issued++;
            end
            step();
        end
        stall6 = 1'b0;
        total++;
        if (!fin || consumed != 48 || mx != 45) begin
            bad++;
            $display("FAIL w6_end got=fin%0b beats%0d max3=%0d want=fin1 beats48 max3=45", fin, consumed, mx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_stall_replay();
        test_flush_stall();
        test_reset_mid();
        test_start_held();
        test_random_stall();
        test_exp_w6();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
